mrnaiso_seq: RTL and testbench
==============================

# mrnaiso_seq

Run sequencer for a SIZE-channel mRNA isolation bank. Accepts a start request with a channel mask and drives every valve-control line of the bank through the fixed protocol. The protocol is load, lyse, peristaltic mix, separate, collect, with an optional flush phase. It sits between the host command interface and the bank's control inputs, replacing static per-signal control with a timed, per-channel-masked sequence.

## Interface
- SIZE, 7, number of bank channels; every valve bus is SIZE wide.
- PHASE_W, 16, width of the phase-length counter and the `phase_len` / `mix_len` inputs.
- PUMP_DIV, 4, clock cycles per peristaltic pump step; must be ≥1.

- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  run request, sampled each cycle.
- abort  in  1  synchronous abort request.
- chan_mask  in  SIZE  channels to run; latched on an accepted start.
- phase_len  in  PHASE_W  cycles per timed phase; latched on start; 0 is treated as 1.
- mix_len  in  PHASE_W  pump periods in MIX; latched on start; 0 skips MIX.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse when a run completes normally.
- phase  out  3  current state encoding.
- Valve buses, each `out  SIZE`, 1 = valve open, gated by the latched mask: cells_in_ctrl, cells_out_ctrl, beads_ctrl, lysis_in_ctrl, lysis_out_ctrl, pump1, pump2, pump3, sep_ctrl, sieve_ctrl, waste_ctrl, push_ctrl, collect_ctrl.
- flush  out  SIZE  flush-line drive; present only with MRNAISO_SEQ_FLUSH_EN.

## Operation
- States and `phase` codes: IDLE=0, LOAD=1, LYSE=2, MIX=3, SEP=4, COLLECT=5, FLUSH=6.
- IDLE: all valve buses are 0 and busy=0.
- Start acceptance:
  - start=1 in IDLE with chan_mask≠0 latches mask, phase_len and mix_len, then enters LOAD.
  - start with mask=0 is ignored.
  - start while busy is ignored.
- LOAD: cells_in_ctrl, cells_out_ctrl and beads_ctrl = mask.
- LYSE: lysis_in_ctrl and lysis_out_ctrl = mask.
- MIX: pumps step through the pattern {pump1,pump2,pump3} = 100 → 010 → 001 → 100 …
  - Each step lasts PUMP_DIV cycles.
  - Each asserted pump bus = mask.
  - One period is 3 steps; MIX runs mix_len periods, then exits.
- SEP: sep_ctrl, sieve_ctrl, waste_ctrl and push_ctrl = mask.
- COLLECT: push_ctrl and collect_ctrl = mask.
- After COLLECT the sequencer enters FLUSH (if compiled in), otherwise IDLE with done=1.
- Unlisted buses are 0 in every state. Exactly one state's buses are active at a time, with no overlap cycle.
- LOAD, LYSE, SEP, COLLECT and FLUSH each last exactly max(phase_len,1) cycles.
- Abort:
  - abort=1 while busy returns to IDLE on the next edge, with all buses 0 and no done.
  - abort has priority over phase advance.
  - abort in IDLE has no effect.
  - abort and start in the same IDLE cycle: start is ignored.
- The internal counter counts down from the latched length; the transition occurs when it reaches 1. No wrap-around is permitted.

## Timing
- Reset: phase=0, busy=0, done=0, all valve buses and flush = 0, latched registers = 0.
- All outputs are registered. `phase` and the valve buses change on the same edge.
- Start accepted on the edge ending cycle T: LOAD is active from T+1, with busy=1 from T+1.
- Total run length R = 4·L + 3·PUMP_DIV·M (+L with flush), where L=max(phase_len,1) and M=mix_len.
- done=1 and busy=0 in cycle T+1+R; IDLE resumes in the same cycle.
- A new start is accepted in the done cycle, so back-to-back runs have no dead cycle.
- Input changes to chan_mask, phase_len or mix_len during a run have no effect.
- rst_n=0 mid-run forces the reset values on the next edge, overriding abort and start.

## Configuration
- MRNAISO_SEQ_FLUSH_EN defined:
  - `flush` port exists.
  - COLLECT is followed by FLUSH for L cycles, with flush=mask and waste_ctrl=mask.
  - done follows FLUSH.
- MRNAISO_SEQ_FLUSH_EN undefined:
  - No `flush` port and no FLUSH state.
  - Code 6 is never produced.

## Test plan
- Basic run, no flush: SIZE=7, PUMP_DIV=2, mask=7'b0000101, phase_len=4, mix_len=2, start at T.
  - LOAD T+1..T+4, LYSE T+5..T+8, MIX T+9..T+20, SEP T+21..T+24, COLLECT T+25..T+28.
  - done=1 at T+29; every active bus = 7'b0000101.
- Pump pattern: same configuration.
  - pump1 is high T+9..T+10, pump2 T+11..T+12, pump3 T+13..T+14, pump1 again T+15..T+16.
  - No two pump buses are high in the same cycle.
- Edge lengths: phase_len=0, mix_len=0, mask=all ones.
  - Each timed phase lasts 1 cycle, MIX is never entered (phase 2→4), done at T+5.
- Ignored starts: start with mask=0 leaves busy low. A second start mid-run does not change the sequence or the latched values.
- Abort and reset: abort at T+10 gives phase=0 and all buses 0 at T+11, with no done. rst_n=0 at T+6 gives reset values at T+7.
- Flush build: with MRNAISO_SEQ_FLUSH_EN and the basic configuration, FLUSH runs T+29..T+32 with flush=waste_ctrl=7'b0000101, and done=1 at T+33.

Source files
------------

// File: rtl/mrnaiso_seq.sv
// mrnaiso_seq: timed, channel-masked run sequencer for an mRNA isolation bank.
// Define MRNAISO_SEQ_FLUSH_EN to add the FLUSH phase and the flush port.
module mrnaiso_seq #(
   parameter int SIZE     = 7,
   parameter int PHASE_W  = 16,
   parameter int PUMP_DIV = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               abort,
   input  logic [SIZE-1:0]    chan_mask,
   input  logic [PHASE_W-1:0] phase_len,
   input  logic [PHASE_W-1:0] mix_len,
   output logic               busy,
   output logic               done,
   output logic [2:0]         phase,
   output logic [SIZE-1:0]    cells_in_ctrl,
   output logic [SIZE-1:0]    cells_out_ctrl,
   output logic [SIZE-1:0]    beads_ctrl,
   output logic [SIZE-1:0]    lysis_in_ctrl,
   output logic [SIZE-1:0]    lysis_out_ctrl,
   output logic [SIZE-1:0]    pump1,
   output logic [SIZE-1:0]    pump2,
   output logic [SIZE-1:0]    pump3,
   output logic [SIZE-1:0]    sep_ctrl,
   output logic [SIZE-1:0]    sieve_ctrl,
   output logic [SIZE-1:0]    waste_ctrl,
   output logic [SIZE-1:0]    push_ctrl,
   output logic [SIZE-1:0]    collect_ctrl
`ifdef MRNAISO_SEQ_FLUSH_EN
   ,
   output logic [SIZE-1:0]    flush
`endif
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      LYSE    = 3'd2,
      MIX     = 3'd3,
      SEP     = 3'd4,
      COLLECT = 3'd5,
      FLUSH   = 3'd6
   } state_t;

   localparam logic [PHASE_W-1:0] DIV = PHASE_W'(PUMP_DIV);
   localparam logic [PHASE_W-1:0] ONE = PHASE_W'(1);

   state_t                     state_q, state_d;
   logic [PHASE_W-1:0]         cnt_q, cnt_d;
   logic [PHASE_W-1:0]         per_q, per_d;
   logic [1:0]                 step_q, step_d;
   logic [SIZE-1:0]            mask_q, mask_d;
   logic [PHASE_W-1:0]         len_q, len_d;
   logic [PHASE_W-1:0]         mix_q, mix_d;
   logic [12:0][SIZE-1:0]      vlv_q, vlv_d;
   logic                       busy_q, done_q, done_d;
   logic                       last;
`ifdef MRNAISO_SEQ_FLUSH_EN
   logic [SIZE-1:0]            flush_q, flush_d;
`endif

   assign last = (cnt_q == ONE);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      per_d   = per_q;
      step_d  = step_q;
      mask_d  = mask_q;
      len_d   = len_q;
      mix_d   = mix_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && !abort && |chan_mask) begin
               state_d = LOAD;
               mask_d  = chan_mask;
               len_d   = (phase_len == '0) ? ONE : phase_len;
               mix_d   = mix_len;
               cnt_d   = len_d;
            end
         end
         LOAD: begin
            state_d = last ? LYSE : LOAD;
            cnt_d   = last ? len_q : cnt_q - ONE;
         end
         LYSE: begin
            if (last && mix_q != '0) begin
               state_d = MIX;
               cnt_d   = DIV;
               step_d  = 2'd0;
               per_d   = mix_q;
            end else begin
               state_d = last ? SEP : LYSE;
               cnt_d   = last ? len_q : cnt_q - ONE;
            end
         end
         MIX: begin
            // cnt paces one pump step; step walks pump1..pump3; per counts periods
            if (!last) cnt_d = cnt_q - ONE;
            else if (step_q != 2'd2) begin
               step_d = step_q + 2'd1;
               cnt_d  = DIV;
            end else if (per_q != ONE) begin
               step_d = 2'd0;
               per_d  = per_q - ONE;
               cnt_d  = DIV;
            end else begin
               state_d = SEP;
               cnt_d   = len_q;
            end
         end
         SEP: begin
            state_d = last ? COLLECT : SEP;
            cnt_d   = last ? len_q : cnt_q - ONE;
         end
         COLLECT: begin
`ifdef MRNAISO_SEQ_FLUSH_EN
            state_d = last ? FLUSH : COLLECT;
            cnt_d   = last ? len_q : cnt_q - ONE;
`else
            state_d = last ? IDLE : COLLECT;
            done_d  = last;
            cnt_d   = last ? cnt_q : cnt_q - ONE;
`endif
         end
`ifdef MRNAISO_SEQ_FLUSH_EN
         FLUSH: begin
            state_d = last ? IDLE : FLUSH;
            done_d  = last;
            cnt_d   = last ? cnt_q : cnt_q - ONE;
         end
`endif
         default: state_d = IDLE;
      endcase
      if (abort && state_q != IDLE) begin
         state_d = IDLE;
         done_d  = 1'b0;
      end
   end

   // Buses are decoded from the next state so they register on the same edge as phase
   always_comb begin
      vlv_d = '0;
`ifdef MRNAISO_SEQ_FLUSH_EN
      flush_d = '0;
`endif
      case (state_d)
         LOAD: begin
            vlv_d[0] = mask_d;
            vlv_d[1] = mask_d;
            vlv_d[2] = mask_d;
         end
         LYSE: begin
            vlv_d[3] = mask_d;
            vlv_d[4] = mask_d;
         end
         MIX: begin
            vlv_d[5] = (step_d == 2'd0) ? mask_d : '0;
            vlv_d[6] = (step_d == 2'd1) ? mask_d : '0;
            vlv_d[7] = (step_d == 2'd2) ? mask_d : '0;
         end
         SEP: begin
            vlv_d[8]  = mask_d;
            vlv_d[9]  = mask_d;
            vlv_d[10] = mask_d;
            vlv_d[11] = mask_d;
         end
         COLLECT: begin
            vlv_d[11] = mask_d;
            vlv_d[12] = mask_d;
         end
`ifdef MRNAISO_SEQ_FLUSH_EN
         FLUSH: begin
            vlv_d[10] = mask_d;
            flush_d   = mask_d;
         end
`endif
         default: vlv_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         per_q   <= '0;
         step_q  <= '0;
         mask_q  <= '0;
         len_q   <= '0;
         mix_q   <= '0;
         vlv_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef MRNAISO_SEQ_FLUSH_EN
         flush_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         per_q   <= per_d;
         step_q  <= step_d;
         mask_q  <= mask_d;
         len_q   <= len_d;
         mix_q   <= mix_d;
         vlv_q   <= vlv_d;
         busy_q  <= (state_d != IDLE);
         done_q  <= done_d;
`ifdef MRNAISO_SEQ_FLUSH_EN
         flush_q <= flush_d;
`endif
      end
   end

   assign busy           = busy_q;
   assign done           = done_q;
   assign phase          = state_q;
   assign cells_in_ctrl  = vlv_q[0];
   assign cells_out_ctrl = vlv_q[1];
   assign beads_ctrl     = vlv_q[2];
   assign lysis_in_ctrl  = vlv_q[3];
   assign lysis_out_ctrl = vlv_q[4];
   assign pump1          = vlv_q[5];
   assign pump2          = vlv_q[6];
   assign pump3          = vlv_q[7];
   assign sep_ctrl       = vlv_q[8];
   assign sieve_ctrl     = vlv_q[9];
   assign waste_ctrl     = vlv_q[10];
   assign push_ctrl      = vlv_q[11];
   assign collect_ctrl   = vlv_q[12];
`ifdef MRNAISO_SEQ_FLUSH_EN
   assign flush          = flush_q;
`endif

endmodule

// File: tb/tb_mrnaiso_seq.sv
// tb_mrnaiso_seq: randomized bench for mrnaiso_seq against a per-cycle timeline model.
module tb_mrnaiso_seq;
   localparam int SIZE = 7;
   localparam int PW   = 16;
   localparam int PD   = 2;

   logic            clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
   logic [SIZE-1:0] chan_mask = '0;
   logic [PW-1:0]   phase_len = '0, mix_len = '0;
   logic            busy, done;
   logic [2:0]      phase;
   logic [SIZE-1:0] cells_in_ctrl, cells_out_ctrl, beads_ctrl, lysis_in_ctrl, lysis_out_ctrl;
   logic [SIZE-1:0] pump1, pump2, pump3, sep_ctrl, sieve_ctrl, waste_ctrl, push_ctrl, collect_ctrl;
`ifdef MRNAISO_SEQ_FLUSH_EN
   logic [SIZE-1:0] flush;
`endif
   logic [13*SIZE-1:0] act;
   int n_tests = 0, n_fail = 0;
   int ph_q[$];
   logic [12:0] en_q[$];

   always #5 clk = ~clk;

   mrnaiso_seq #(.SIZE(SIZE), .PHASE_W(PW), .PUMP_DIV(PD)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .chan_mask(chan_mask),
      .phase_len(phase_len), .mix_len(mix_len), .busy(busy), .done(done), .phase(phase),
      .cells_in_ctrl(cells_in_ctrl), .cells_out_ctrl(cells_out_ctrl), .beads_ctrl(beads_ctrl),
      .lysis_in_ctrl(lysis_in_ctrl), .lysis_out_ctrl(lysis_out_ctrl),
      .pump1(pump1), .pump2(pump2), .pump3(pump3), .sep_ctrl(sep_ctrl), .sieve_ctrl(sieve_ctrl),
      .waste_ctrl(waste_ctrl), .push_ctrl(push_ctrl), .collect_ctrl(collect_ctrl)
`ifdef MRNAISO_SEQ_FLUSH_EN
      , .flush(flush)
`endif
   );

   assign act = {collect_ctrl, push_ctrl, waste_ctrl, sieve_ctrl, sep_ctrl, pump3, pump2, pump1,
                 lysis_out_ctrl, lysis_in_ctrl, beads_ctrl, cells_out_ctrl, cells_in_ctrl};

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected per-cycle timeline of one full run: (phase code, set of open buses)
   task automatic build(input int l, input int m);
      ph_q.delete();
      en_q.delete();
      for (int k = 0; k < l; k++) begin ph_q.push_back(1); en_q.push_back(13'b0000000000111); end
      for (int k = 0; k < l; k++) begin ph_q.push_back(2); en_q.push_back(13'b0000000011000); end
      for (int p = 0; p < m; p++)
         for (int s = 0; s < 3; s++)
            for (int d = 0; d < PD; d++) begin ph_q.push_back(3); en_q.push_back(13'b1 << (5 + s)); end
      for (int k = 0; k < l; k++) begin ph_q.push_back(4); en_q.push_back(13'b0111100000000); end
      for (int k = 0; k < l; k++) begin ph_q.push_back(5); en_q.push_back(13'b1100000000000); end
`ifdef MRNAISO_SEQ_FLUSH_EN
      for (int k = 0; k < l; k++) begin ph_q.push_back(6); en_q.push_back(13'b0010000000000); end
`endif
   endtask

   task automatic chk_out(input string tag, input int ph, input logic [12:0] en,
                          input logic [SIZE-1:0] m, input logic b, input logic d);
      logic [13*SIZE-1:0] e;
      e = '0;
      for (int k = 0; k < 13; k++) if (en[k]) e[k*SIZE +: SIZE] = m;
      chk({tag, ".phase"}, 128'(phase), 128'(ph));
      chk({tag, ".buses"}, 128'(act), 128'(e));
      chk({tag, ".busy"}, 128'(busy), 128'(b));
      chk({tag, ".done"}, 128'(done), 128'(d));
`ifdef MRNAISO_SEQ_FLUSH_EN
      chk({tag, ".flush"}, 128'(flush), (ph == 6) ? 128'(m) : 128'(0));
`endif
   endtask

   // Called at a negedge; stop_at >= 0 aborts (or resets) in that run cycle
   task automatic run(input logic [SIZE-1:0] m, input int pl, input int ml,
                      input int stop_at, input bit use_rst, input bit noise);
      int l;
      l = (pl == 0) ? 1 : pl;
      start = 1'b1; chan_mask = m; phase_len = PW'(pl); mix_len = PW'(ml);
      build(l, ml);
      for (int i = 0; i < ph_q.size(); i++) begin
         @(negedge clk);
         chk_out($sformatf("run m%0h l%0d m%0d c%0d", m, pl, ml, i), ph_q[i], en_q[i], m, 1'b1, 1'b0);
         start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         if (noise) begin
            chan_mask = SIZE'($urandom); phase_len = PW'($urandom_range(0, 9)); mix_len = PW'($urandom_range(0, 4));
         end
         if (i == stop_at) begin
            if (use_rst) begin rst_n = 1'b0; start = 1'b1; abort = 1'b1; chan_mask = m; end
            else abort = 1'b1;
            @(negedge clk);
            chk_out(use_rst ? "reset" : "abort", 0, '0, m, 1'b0, 1'b0);
            rst_n = 1'b1; abort = 1'b0; start = 1'b0;
            return;
         end
      end
      @(negedge clk);
      chk_out($sformatf("done m%0h", m), 0, '0, m, 1'b0, 1'b1);
      start = 1'b0;
   endtask

   task automatic idle_chk(input string tag);
      chk_out(tag, 0, '0, '0, 1'b0, 1'b0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      idle_chk("in_reset");
      rst_n = 1'b1;
      @(negedge clk); idle_chk("after_reset");
      start = 1'b1; chan_mask = '0; phase_len = 3; mix_len = 1;
      @(negedge clk); idle_chk("mask0");
      chan_mask = 7'b0000101; abort = 1'b1;
      @(negedge clk); idle_chk("start_abort");
      start = 1'b0;
      @(negedge clk); idle_chk("abort_idle");
      abort = 1'b0;
      run(7'b0000101, 4, 2, -1, 1'b0, 1'b0);
      @(negedge clk); idle_chk("post_basic");
      run(7'h7f, 0, 0, -1, 1'b0, 1'b0);
      @(negedge clk); idle_chk("post_edge");
      run(7'b0000101, 4, 2, -1, 1'b0, 1'b1);
      @(negedge clk); idle_chk("post_noise");
      run(7'b0000101, 4, 2, 9, 1'b0, 1'b0);
      @(negedge clk); idle_chk("post_abort");
      run(7'b0000101, 4, 2, 5, 1'b1, 1'b0);
      @(negedge clk); idle_chk("post_reset");
      run(7'h33, 2, 1, -1, 1'b0, 1'b0);
      run(7'h4c, 3, 0, -1, 1'b0, 1'b0);
      @(negedge clk); idle_chk("post_b2b");
      for (int r = 0; r < 25; r++) begin
         logic [SIZE-1:0] m;
         int pl, ml, stop;
         m = SIZE'($urandom_range(1, 127));
         pl = $urandom_range(0, 6);
         ml = $urandom_range(0, 3);
         stop = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 8) : -1;
         run(m, pl, ml, stop, 1'($urandom_range(0, 1)) && stop >= 0 && r[0], 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 1) == 1) begin
            @(negedge clk); idle_chk($sformatf("rand_idle%0d", r));
         end
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
